// File: rtl/speed_req_sched_if.sv
// speed_req_sched_if: detection input, line config, speed-block link and status of the scheduler
interface speed_req_sched_if #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
);
  logic             det_valid;
  logic             det_ready;
  logic [DEPTH-1:0] det_id;
  logic [WIDTH-1:0] det_x;
  logic [WIDTH-1:0] det_y;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_x;
  logic [WIDTH-1:0] cfg_y;
  logic             spd_start;
  logic [WIDTH-1:0] spd_car;
  logic [WIDTH-1:0] spd_x;
  logic [WIDTH-1:0] spd_y;
  logic             spd_wen_speed;
  logic             spd_wen_loc;
  logic             busy;
  logic             done;
  logic [DEPTH-1:0] done_id;
  logic             timeout_err;
  logic [15:0]      rec_cnt;
  modport slave (
    input  det_valid, det_id, det_x, det_y, cfg_we, cfg_x, cfg_y, spd_wen_speed, spd_wen_loc,
    output det_ready, spd_start, spd_car, spd_x, spd_y, busy, done, done_id, timeout_err, rec_cnt
  );
  modport master (
    output det_valid, det_id, det_x, det_y, cfg_we, cfg_x, cfg_y, spd_wen_speed, spd_wen_loc,
    input  det_ready, spd_start, spd_car, spd_x, spd_y, busy, done, done_id, timeout_err, rec_cnt
  );
endinterface

// File: rtl/speed_req_sched.sv
// speed_req_sched: serialises one detection into id/x/y start beats for the speed block,
// then waits for its write enables and reports done or timeout.
module speed_req_sched #(
  parameter int WIDTH   = 9,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  speed_req_sched_if.slave io_bus
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, S_ID, S_X, S_Y, S_WAIT} state_t;
  state_t           r_state, w_next;
  logic [DEPTH-1:0] r_id, r_done_id;
  logic [WIDTH-1:0] r_x, r_y, r_car, w_car, r_cfg_x, r_cfg_y;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_rec;
  logic             r_start, w_start, r_done, w_done, r_terr, w_terr;
  logic             w_acc, w_wen, w_tmo;
  assign w_acc = (r_state == IDLE) && io_bus.det_valid;
  assign w_wen = io_bus.spd_wen_speed | io_bus.spd_wen_loc;
  assign w_tmo = r_cnt == CW'(TIMEOUT - 1);
  // Beat outputs are computed for the next state so they leave the flops aligned with it
  always_comb begin
    w_next  = r_state;
    w_car   = r_car;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_terr  = 1'b0;
    case (r_state)
      IDLE: if (w_acc) begin
        w_next  = S_ID;
        w_car   = WIDTH'(io_bus.det_id);
        w_start = 1'b1;
      end
      S_ID: begin
        w_next  = S_X;
        w_car   = r_x;
        w_start = 1'b1;
      end
      S_X: begin
        w_next  = S_Y;
        w_car   = r_y;
        w_start = 1'b1;
      end
      S_Y: w_next = S_WAIT;
      S_WAIT: begin
        w_done = w_wen;
        w_terr = !w_wen && w_tmo;
        w_next = (w_wen || w_tmo) ? IDLE : S_WAIT;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_id      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_car     <= '0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_terr    <= 1'b0;
      r_done_id <= '0;
      r_cfg_x   <= '0;
      r_cfg_y   <= '0;
      r_cnt     <= '0;
      r_rec     <= '0;
    end else begin
      r_state <= w_next;
      r_car   <= w_car;
      r_start <= w_start;
      r_done  <= w_done;
      r_terr  <= w_terr;
      r_cnt   <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
      if (w_acc) begin
        r_id <= io_bus.det_id;
        r_x  <= io_bus.det_x;
        r_y  <= io_bus.det_y;
      end
      // Config only moves between records so a record always sees one measurement line
      if (r_state == IDLE && io_bus.cfg_we && !w_acc) begin
        r_cfg_x <= io_bus.cfg_x;
        r_cfg_y <= io_bus.cfg_y;
      end
      if (w_done || w_terr) r_done_id <= r_id;
      if (w_done) r_rec <= r_rec + 16'd1;
    end
  end
  assign io_bus.det_ready   = (r_state == IDLE) && !rst;
  assign io_bus.busy        = r_state != IDLE;
  assign io_bus.spd_start   = r_start;
  assign io_bus.spd_car     = r_car;
  assign io_bus.spd_x       = r_cfg_x;
  assign io_bus.spd_y       = r_cfg_y;
  assign io_bus.done        = r_done;
  assign io_bus.done_id     = r_done_id;
  assign io_bus.timeout_err = r_terr;
  assign io_bus.rec_cnt     = r_rec;
endmodule

// File: tb/tb_speed_req_sched.sv
// tb_speed_req_sched: randomized records checked against a transaction-level model of the scheduler
module tb_speed_req_sched;
  localparam int W  = 9;
  localparam int D  = 8;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  speed_req_sched_if #(.WIDTH(W), .DEPTH(D)) bus();
  speed_req_sched #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .io_bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0]  m_x = '0;
  logic [W-1:0]  m_y = '0;
  logic [15:0]   m_rec = '0;
  logic [D-1:0]  m_did = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic clear_in();
    bus.det_valid     = 1'b0;
    bus.cfg_we        = 1'b0;
    bus.spd_wen_speed = 1'b0;
    bus.spd_wen_loc   = 1'b0;
  endtask
  task automatic idle_cyc(input bit cfg, input bit wen);
    logic [W-1:0] cx, cy;
    cx = W'($urandom);
    cy = W'($urandom);
    bus.cfg_we = cfg;
    bus.cfg_x  = cx;
    bus.cfg_y  = cy;
    bus.spd_wen_speed = wen;
    bus.spd_wen_loc   = wen;
    @(negedge clk);
    clear_in();
    if (cfg) begin
      m_x = cx;
      m_y = cy;
    end
    chk("idle_x", 32'(bus.spd_x), 32'(m_x));
    chk("idle_y", 32'(bus.spd_y), 32'(m_y));
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_rec", 32'(bus.rec_cnt), 32'(m_rec));
    chk("idle_ready", 32'(bus.det_ready), 1);
  endtask
  // wk: WAIT cycle carrying a write enable, -1 for none (timeout expected)
  task automatic do_rec(input logic [D-1:0] id, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int wk, input bit junk, input bit cfg_acc);
    logic [W-1:0] exp_car;
    bit hit, sel, last;
    chk("acc_ready", 32'(bus.det_ready), 1);
    bus.det_valid = 1'b1;
    bus.det_id    = id;
    bus.det_x     = x;
    bus.det_y     = y;
    bus.cfg_we    = cfg_acc;
    bus.cfg_x     = ~m_x;
    bus.cfg_y     = ~m_y;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bus.det_valid     = junk;
      bus.det_id        = D'($urandom);
      bus.det_x         = W'($urandom);
      bus.det_y         = W'($urandom);
      bus.cfg_we        = junk;
      bus.cfg_x         = W'($urandom);
      bus.cfg_y         = W'($urandom);
      bus.spd_wen_speed = junk;
      bus.spd_wen_loc   = junk;
      exp_car = (b == 0) ? W'(id) : (b == 1) ? x : y;
      chk("beat_start", 32'(bus.spd_start), 1);
      chk("beat_car", 32'(bus.spd_car), 32'(exp_car));
      chk("beat_ready", 32'(bus.det_ready), 0);
      chk("beat_busy", 32'(bus.busy), 1);
      chk("beat_done", 32'(bus.done), 0);
      chk("beat_cfg_x", 32'(bus.spd_x), 32'(m_x));
    end
    @(negedge clk);
    clear_in();
    chk("wait_start", 32'(bus.spd_start), 0);
    chk("wait_car", 32'(bus.spd_car), 32'(y));
    chk("wait_cfg_y", 32'(bus.spd_y), 32'(m_y));
    chk("wait_rec", 32'(bus.rec_cnt), 32'(m_rec));
    for (int k = 0; k < TO; k++) begin
      hit  = (k == wk);
      last = (k == TO - 1);
      sel  = 1'($urandom_range(0, 1));
      bus.spd_wen_speed = hit & sel;
      bus.spd_wen_loc   = hit & ~sel;
      @(negedge clk);
      clear_in();
      if (hit) m_rec++;
      if (hit || last) m_did = id;
      chk("wait_done", 32'(bus.done), 32'(hit));
      chk("wait_tmo", 32'(bus.timeout_err), 32'(!hit && last));
      chk("wait_done_id", 32'(bus.done_id), 32'(m_did));
      chk("wait_rec_cnt", 32'(bus.rec_cnt), 32'(m_rec));
      chk("wait_busy", 32'(bus.busy), 32'(!(hit || last)));
      if (hit) break;
    end
    chk("end_ready", 32'(bus.det_ready), 1);
  endtask
  initial begin
    clear_in();
    bus.det_id = '0;
    bus.det_x  = '0;
    bus.det_y  = '0;
    bus.cfg_x  = '0;
    bus.cfg_y  = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.det_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_car", 32'(bus.spd_car), 0);
    chk("rst_start", 32'(bus.spd_start), 0);
    chk("rst_rec", 32'(bus.rec_cnt), 0);
    chk("rst_done_id", 32'(bus.done_id), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.det_ready), 1);
    bus.cfg_we = 1'b1;
    bus.cfg_x  = W'(100);
    bus.cfg_y  = W'(354);
    @(negedge clk);
    clear_in();
    m_x = W'(100);
    m_y = W'(354);
    chk("cfg_x", 32'(bus.spd_x), 100);
    chk("cfg_y", 32'(bus.spd_y), 354);
    do_rec(D'(100), W'(100), W'(310), 2, 1'b0, 1'b0);
    do_rec(D'(7), W'(1), W'(2), -1, 1'b0, 1'b0);
    do_rec(D'(55), W'(3), W'(4), 5, 1'b1, 1'b1);
    do_rec(D'(200), W'(511), W'(0), TO - 1, 1'b0, 1'b0);
    do_rec(D'(9), W'(8), W'(7), 0, 1'b1, 1'b0);
    idle_cyc(1'b0, 1'b1);
    for (int r = 0; r < 25; r++) begin
      int n_idle, wk;
      n_idle = $urandom_range(0, 3);
      for (int i = 0; i < n_idle; i++) idle_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wk = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      do_rec(D'($urandom), W'($urandom), W'($urandom), wk, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end
    bus.det_valid = 1'b1;
    bus.det_id    = D'(33);
    bus.det_x     = W'(44);
    bus.det_y     = W'(66);
    @(negedge clk);
    clear_in();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_car", 32'(bus.spd_car), 66);
    rst = 1'b1;
    @(negedge clk);
    m_rec = '0;
    m_did = '0;
    m_x   = '0;
    m_y   = '0;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_start", 32'(bus.spd_start), 0);
    chk("mid_rst_car", 32'(bus.spd_car), 0);
    chk("mid_rst_rec", 32'(bus.rec_cnt), 0);
    chk("mid_rst_x", 32'(bus.spd_x), 0);
    chk("mid_rst_ready", 32'(bus.det_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_after", 32'(bus.det_ready), 1);
    do_rec(D'(12), W'(34), W'(56), 1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
